// File: rtl/cpu_pkg.sv
// Shared CPU control types: opcodes, ALU codes,
// control FSM states and the decoded control bundle.
package cpu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h0,
    OP_STORE = 4'h1,
    OP_XOR   = 4'h2,
    OP_BNE   = 4'h3,
    OP_ADD   = 4'h4,
    OP_MV    = 4'h5,
    OP_LSH   = 4'h6,
    OP_RSH   = 4'h7,
    OP_LOADI = 4'h8,
    OP_PARI  = 4'h9,
    OP_HALT  = 4'hA,
    OP_OR    = 4'hB,
    OP_SUB   = 4'hC
  } op_e;

  localparam logic [ALU_W-1:0] ALU_XOR = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_BNE = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_LSH = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_RSH = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_LDI = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_NOP = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_PAR = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_MV  = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b1011;

  localparam logic [1:0] RD_R0 = 2'd0;
  localparam logic [1:0] RD_RS = 2'd1;
  localparam logic [1:0] RD_RT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MEM_WAIT,
    S_HALTED
  } ctrl_state_e;

  typedef struct packed {
    logic             branch;
    logic             memtoreg;
    logic             memwrite;
    logic             alusrc;
    logic             regwrite;
    logic [ALU_W-1:0] aluop;
    logic [1:0]       regdst;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    branch:   1'b0,
    memtoreg: 1'b0,
    memwrite: 1'b0,
    alusrc:   1'b0,
    regwrite: 1'b0,
    aluop:    ALU_NOP,
    regdst:   RD_R0
  };

  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c = CTRL_IDLE;
    c.regwrite = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational opcode decoder. Illegal opcodes
// come out as a nop that writes nothing.
module ctrl_decode_comb
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      ctrl,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    ctrl    = ctrl_nop();
    is_halt = 1'b0;
    illegal = 1'b0;
    unique case (op)
      OP_LOAD: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regdst   = RD_RS;
      end
      OP_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.regwrite = 1'b0;
      end
      OP_XOR: ctrl.aluop = ALU_XOR;
      OP_BNE: begin
        ctrl.aluop    = ALU_BNE;
        ctrl.branch   = 1'b1;
        ctrl.regwrite = 1'b0;
      end
      OP_ADD: ctrl.aluop = ALU_ADD;
      OP_MV: begin
        ctrl.aluop  = ALU_MV;
        ctrl.regdst = RD_RT;
      end
      OP_LSH: begin
        ctrl.aluop  = ALU_LSH;
        ctrl.alusrc = 1'b1;
        ctrl.regdst = RD_RS;
      end
      OP_RSH: begin
        ctrl.aluop  = ALU_RSH;
        ctrl.alusrc = 1'b1;
        ctrl.regdst = RD_RS;
      end
      OP_LOADI: begin
        ctrl.aluop  = ALU_LDI;
        ctrl.alusrc = 1'b1;
        ctrl.regdst = RD_RS;
      end
      OP_PARI: begin
        ctrl.aluop  = ALU_PAR;
        ctrl.alusrc = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      OP_OR:   ctrl.aluop = ALU_OR;
      OP_SUB:  ctrl.aluop = ALU_SUB;
      default: begin
        ctrl.regwrite = 1'b0;
        illegal       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_pipe.sv
// Registered control unit: decode, load wait
// sequencing, sticky halt and illegal-op flag.
module ctrl_fsm_pipe
  import cpu_pkg::*;
#(
  parameter int MCODE_W = 9,
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 4,
  parameter int MEM_LAT = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [MCODE_W-1:0] Instr,
  input  logic               InstrValid,
  output logic               CtrlValid,
  output logic               Branch,
  output logic               MemtoReg,
  output logic               MemWrite,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         RegDst,
  output logic               Stall,
  output logic               Halt,
  output logic               IllegalOp
);

  localparam int CW =
    (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT = CW'(MEM_LAT);
  localparam logic LAT_EN  = (MEM_LAT > 0);
  localparam logic LAT_ONE = (MEM_LAT == 1);

  ctrl_state_e   state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  ctrl_t         ctl_q;
  logic          vld_q;
  logic          stall_q;
  logic          halt_q;
  logic          ill_q;

  logic [3:0] op;
  ctrl_t      dec;
  ctrl_t      ld_ctl;
  logic       dec_halt;
  logic       dec_ill;
  logic       ld_wait;
  logic       unused_bits;

  assign op = 4'(Instr[MCODE_W-1 -: OP_W]);
  assign unused_bits = ^Instr[MCODE_W-OP_W-1:0];

  ctrl_decode_comb u_dec (
    .op      (op),
    .ctrl    (dec),
    .is_halt (dec_halt),
    .illegal (dec_ill)
  );

  // Register write of a multi-cycle load is held
  // back until the last wait cycle.
  always_comb begin
    ld_ctl          = dec;
    ld_ctl.regwrite = LAT_ONE;
    ld_wait = LAT_EN && (op == OP_LOAD);
    cnt_nx  = cnt - 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ctl_q   <= CTRL_IDLE;
      vld_q   <= 1'b0;
      stall_q <= 1'b0;
      halt_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          stall_q <= 1'b1;
          if (Start) begin
            state   <= S_RUN;
            stall_q <= 1'b0;
          end
        end
        S_RUN: begin
          ctl_q   <= CTRL_IDLE;
          vld_q   <= 1'b0;
          stall_q <= 1'b0;
          if (InstrValid) begin
            unique case (1'b1)
              dec_halt: begin
                halt_q  <= 1'b1;
                stall_q <= 1'b1;
                state   <= S_HALTED;
              end
              ld_wait: begin
                ctl_q   <= ld_ctl;
                vld_q   <= 1'b1;
                stall_q <= 1'b1;
                cnt     <= LAT;
                state   <= S_MEM_WAIT;
              end
              default: begin
                ctl_q <= dec;
                vld_q <= 1'b1;
                ill_q <= dec_ill;
              end
            endcase
          end
        end
        S_MEM_WAIT: begin
          cnt <= cnt_nx;
          if (cnt_nx == '0) begin
            state   <= S_RUN;
            stall_q <= 1'b0;
            ctl_q   <= CTRL_IDLE;
            vld_q   <= 1'b0;
          end else if (cnt_nx == CW'(1)) begin
            ctl_q.regwrite <= 1'b1;
          end
        end
        S_HALTED: begin
          if (Start) begin
            state   <= S_RUN;
            halt_q  <= 1'b0;
            stall_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign CtrlValid = vld_q;
  assign Branch    = ctl_q.branch;
  assign MemtoReg  = ctl_q.memtoreg;
  assign MemWrite  = ctl_q.memwrite;
  assign ALUSrc    = ctl_q.alusrc;
  assign RegWrite  = ctl_q.regwrite;
  assign ALUOp     = ALUOP_W'(ctl_q.aluop);
  assign RegDst    = ctl_q.regdst;
  assign Stall     = stall_q;
  assign Halt      = halt_q;
  assign IllegalOp = ill_q;

endmodule

// File: tb/tb_ctrl_fsm_pipe.sv
// Bench for ctrl_fsm_pipe: MEM_LAT=2 and MEM_LAT=0
// instances against a behavioural model.
module tb_ctrl_fsm_pipe;

  typedef struct packed {
    logic       vld;
    logic       br;
    logic       m2r;
    logic       mw;
    logic       as;
    logic       rw;
    logic [3:0] aluop;
    logic [1:0] rd;
    logic       stall;
    logic       halt;
    logic       ill;
  } exp_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] rem;
    exp_t       e;
  } model_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [8:0] Instr = '0;
  logic       InstrValid = 1'b0;

  logic cv2, br2, m2r2, mw2, as2, rw2;
  logic st2, h2, il2;
  logic [3:0] alu2;
  logic [1:0] rd2;
  logic cv0, br0, m2r0, mw0, as0, rw0;
  logic st0, h0, il0;
  logic [3:0] alu0;
  logic [1:0] rd0;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;
  model_t m2, m0;

  always #5 Clk = ~Clk;

  ctrl_fsm_pipe #(.MEM_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Instr(Instr), .InstrValid(InstrValid),
    .CtrlValid(cv2), .Branch(br2),
    .MemtoReg(m2r2), .MemWrite(mw2),
    .ALUSrc(as2), .RegWrite(rw2),
    .ALUOp(alu2), .RegDst(rd2), .Stall(st2),
    .Halt(h2), .IllegalOp(il2)
  );

  ctrl_fsm_pipe #(.MEM_LAT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Instr(Instr), .InstrValid(InstrValid),
    .CtrlValid(cv0), .Branch(br0),
    .MemtoReg(m2r0), .MemWrite(mw0),
    .ALUSrc(as0), .RegWrite(rw0),
    .ALUOp(alu0), .RegDst(rd0), .Stall(st0),
    .Halt(h0), .IllegalOp(il0)
  );

  function automatic exp_t quiet();
    exp_t z;
    z = '0;
    z.aluop = 4'd7;
    return z;
  endfunction

  function automatic exp_t ref_dec(logic [3:0] op);
    exp_t e;
    e = quiet();
    e.vld = 1'b1;
    e.rw = 1'b1;
    case (op)
      4'h0: begin e.m2r = 1; e.rd = 2'd1; end
      4'h1: begin e.mw = 1; e.rw = 0; end
      4'h2: e.aluop = 4'd1;
      4'h3: begin
        e.aluop = 4'd2; e.br = 1; e.rw = 0;
      end
      4'h4: e.aluop = 4'd3;
      4'h5: begin e.aluop = 4'd9; e.rd = 2'd2; end
      4'h6: begin
        e.aluop = 4'd4; e.as = 1; e.rd = 2'd1;
      end
      4'h7: begin
        e.aluop = 4'd5; e.as = 1; e.rd = 2'd1;
      end
      4'h8: begin
        e.aluop = 4'd6; e.as = 1; e.rd = 2'd1;
      end
      4'h9: begin e.aluop = 4'd8; e.as = 1; end
      4'hB: e.aluop = 4'd10;
      4'hC: e.aluop = 4'd11;
      default: begin e.rw = 0; e.ill = 1; end
    endcase
    return e;
  endfunction

  function automatic model_t mreset();
    model_t m;
    m = '0;
    m.e = quiet();
    return m;
  endfunction

  // mode: 0 idle, 1 run, 2 load wait, 3 halted
  function automatic model_t step(
    model_t m, logic st, logic iv,
    logic [8:0] ins, int lat);
    model_t n;
    logic [3:0] op;
    n = m;
    op = ins[8:5];
    n.e.ill = 1'b0;
    case (m.mode)
      2'd0: begin
        n.e = quiet();
        n.e.stall = 1'b1;
        if (st) begin
          n.mode = 2'd1;
          n.e.stall = 1'b0;
        end
      end
      2'd1: begin
        n.e = quiet();
        if (iv && op == 4'hA) begin
          n.e.halt = 1'b1;
          n.e.stall = 1'b1;
          n.mode = 2'd3;
        end else if (iv) begin
          n.e = ref_dec(op);
          if (op == 4'h0 && lat > 0) begin
            n.e.rw = (lat == 1);
            n.e.stall = 1'b1;
            n.rem = 8'(lat);
            n.mode = 2'd2;
          end
        end
      end
      2'd2: begin
        n.rem = m.rem - 8'd1;
        if (n.rem == 8'd0) begin
          n.mode = 2'd1;
          n.e = quiet();
        end else if (n.rem == 8'd1) begin
          n.e.rw = 1'b1;
        end
      end
      default: begin
        if (st) begin
          n.mode = 2'd1;
          n.e = quiet();
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m2 <= mreset();
      m0 <= mreset();
    end else begin
      m2 <= step(m2, Start, InstrValid, Instr, 2);
      m0 <= step(m0, Start, InstrValid, Instr, 0);
    end
  end

  task automatic chk(string name,
    logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h",
        name, act, exp);
    end
  endtask

  exp_t a2, a0;
  assign a2 = {cv2, br2, m2r2, mw2, as2, rw2,
               alu2, rd2, st2, h2, il2};
  assign a0 = {cv0, br0, m2r0, mw0, as0, rw0,
               alu0, rd0, st0, h0, il0};

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_lat2", 32'(a2), 32'(m2.e));
      chk("model_lat0", 32'(a0), 32'(m0.e));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic put(logic iv, logic [3:0] op);
    InstrValid = iv;
    Instr = {op, 5'b10101};
  endtask

  logic [3:0] ops [11] = '{
    4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
    4'h8, 4'h9, 4'hB, 4'hC, 4'h1
  };

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge Clk);
    chk("rst_aluop", 32'(alu2), 32'd7);
    chk("rst_stall", 32'(st2), 32'd0);
    chk("rst_vld", 32'(cv2), 32'd0);
    Reset = 1'b1;
    cyc();
    @(negedge Clk);
    chk("idle_stall", 32'(st2), 32'd1);
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    @(negedge Clk);
    chk("run_stall", 32'(st2), 32'd0);
    // add
    put(1, 4'h4);
    cyc();
    put(0, 4'h0);
    @(negedge Clk);
    chk("add_vld", 32'(cv2), 32'd1);
    chk("add_aluop", 32'(alu2), 32'd3);
    chk("add_rw", 32'(rw2), 32'd1);
    cyc();
    @(negedge Clk);
    chk("idle_rw", 32'(rw2), 32'd0);
    for (int i = 0; i < 11; i++) begin
      put(1, ops[i]);
      Start = (i == 3);
      cyc();
      if (i == 3) begin
        @(negedge Clk);
        chk("mv_aluop", 32'(alu2), 32'd9);
        chk("mv_regdst", 32'(rd2), 32'd2);
      end
    end
    Start = 1'b0;
    // load: later instrs ignored while waiting
    put(1, 4'h0);
    cyc();
    put(1, 4'h4);
    @(negedge Clk);
    chk("ld0_stall", 32'(st2), 32'd1);
    chk("ld0_rw", 32'(rw2), 32'd0);
    chk("ld0_m2r", 32'(m2r2), 32'd1);
    chk("ld0_regdst", 32'(rd2), 32'd1);
    chk("lat0_stall", 32'(st0), 32'd0);
    chk("lat0_rw", 32'(rw0), 32'd1);
    chk("lat0_m2r", 32'(m2r0), 32'd1);
    cyc();
    @(negedge Clk);
    chk("ld1_stall", 32'(st2), 32'd1);
    chk("ld1_rw", 32'(rw2), 32'd1);
    cyc();
    @(negedge Clk);
    chk("ld2_stall", 32'(st2), 32'd0);
    chk("ld2_rw", 32'(rw2), 32'd0);
    cyc();
    @(negedge Clk);
    chk("post_ld_add", 32'(alu2), 32'd3);
    // halt, then instrs ignored for 10 cycles
    put(1, 4'hA);
    cyc();
    put(1, 4'h4);
    @(negedge Clk);
    chk("halt", 32'(h2), 32'd1);
    chk("halt_stall", 32'(st2), 32'd1);
    chk("halt_vld", 32'(cv2), 32'd0);
    repeat (10) cyc();
    @(negedge Clk);
    chk("halt_held", 32'(h2), 32'd1);
    chk("halt_rw", 32'(rw2), 32'd0);
    put(0, 4'h0);
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    @(negedge Clk);
    chk("unhalt", 32'(h2), 32'd0);
    chk("unhalt_stall", 32'(st2), 32'd0);
    // illegal opcode
    put(1, 4'hE);
    cyc();
    put(1, 4'h4);
    @(negedge Clk);
    chk("ill_pulse", 32'(il2), 32'd1);
    chk("ill_rw", 32'(rw2), 32'd0);
    cyc();
    put(0, 4'h0);
    @(negedge Clk);
    chk("ill_clear", 32'(il2), 32'd0);
    chk("ill_add", 32'(rw2), 32'd1);
    put(1, 4'hF);
    cyc();
    put(1, 4'hD);
    cyc();
    // reset in the middle of a load
    put(1, 4'h0);
    cyc();
    put(0, 4'h0);
    cyc();
    Reset = 1'b0;
    #1;
    @(negedge Clk);
    chk("abort_rw", 32'(rw2), 32'd0);
    chk("abort_stall", 32'(st2), 32'd0);
    chk("abort_aluop", 32'(alu2), 32'd7);
    cyc();
    Reset = 1'b1;
    repeat (2) cyc();
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    put(1, 4'h0);
    cyc();
    put(0, 4'h0);
    repeat (4) cyc();
    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
